// File: rtl/player_move_controller.sv
// Player motion sequencer: samples a direction at a cell centre, waits out the
// detector latency, then steps the sprite one full cell on frame ticks or reports a block.
`timescale 1ns/1ps
module player_move_controller #(
  parameter int START_X = 455,
  parameter int START_Y = 146,
  parameter int CELL    = 16,
  parameter int STEP    = 2,
  parameter int DET_LAT = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        frame_tick,
  input  logic [3:0]  btn,
  input  logic [3:0]  valid_moves,
  output logic [10:0] pos_x,
  output logic [9:0]  pos_y,
  output logic [3:0]  dir,
  output logic        moving,
  output logic        move_done,
  output logic        blocked
);

  localparam int WCW = $clog2(DET_LAT + 1);
  localparam int PCW = $clog2(CELL + 1);

  localparam logic [WCW-1:0] WAIT_LAST = WCW'(DET_LAT - 1);
  localparam logic [PCW-1:0] STEP_P    = PCW'(STEP);
  localparam logic [PCW-1:0] CELL_P    = PCW'(CELL);
  localparam logic [10:0]    STEP_X    = 11'(STEP);
  localparam logic [9:0]     STEP_Y    = 10'(STEP);
  localparam logic [10:0]    RST_X     = 11'(START_X);
  localparam logic [9:0]     RST_Y     = 10'(START_Y);

  localparam logic [3:0] D_LEFT  = 4'b1000;
  localparam logic [3:0] D_DOWN  = 4'b0100;
  localparam logic [3:0] D_UP    = 4'b0010;
  localparam logic [3:0] D_RIGHT = 4'b0001;

  typedef enum logic [1:0] {
    S_IDLE,
    S_QUERY,
    S_CHECK,
    S_MOVE
  } state_t;

  state_t          state_q, state_d;
  logic [3:0]      req_q, req_d;
  logic [WCW-1:0]  wait_q, wait_d;
  logic [PCW-1:0]  pix_q, pix_d;
  logic [10:0]     x_q, x_d;
  logic [9:0]      y_q, y_d;
  logic [3:0]      dir_q, dir_d;
  logic            moving_q, moving_d;
  logic            done_q, done_d;
  logic            blocked_q, blocked_d;

  // Fixed ranking when several buttons are held: left > down > up > right.
  function automatic logic [3:0] prio_pick(input logic [3:0] b);
    logic [3:0] r;
    r = 4'b0000;
    if (b[3])      r = D_LEFT;
    else if (b[2]) r = D_DOWN;
    else if (b[1]) r = D_UP;
    else if (b[0]) r = D_RIGHT;
    return r;
  endfunction

  always_comb begin
    state_d   = state_q;
    req_d     = req_q;
    wait_d    = wait_q;
    pix_d     = pix_q;
    x_d       = x_q;
    y_d       = y_q;
    dir_d     = dir_q;
    moving_d  = moving_q;
    done_d    = 1'b0;
    blocked_d = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (btn != 4'b0000) begin
          req_d   = prio_pick(btn);
          wait_d  = '0;
          state_d = S_QUERY;
        end
      end
      S_QUERY: begin
        if (wait_q == WAIT_LAST) state_d = S_CHECK;
        else                     wait_d  = wait_q + 1'b1;
      end
      S_CHECK: begin
        if ((valid_moves & req_q) != 4'b0000) begin
          dir_d    = req_q;
          moving_d = 1'b1;
          pix_d    = '0;
          state_d  = S_MOVE;
        end else begin
          blocked_d = 1'b1;
          state_d   = S_IDLE;
        end
      end
      S_MOVE: begin
        if (frame_tick) begin
          unique case (dir_q)
            D_RIGHT: x_d = x_q + STEP_X;
            D_LEFT:  x_d = x_q - STEP_X;
            D_DOWN:  y_d = y_q + STEP_Y;
            D_UP:    y_d = y_q - STEP_Y;
            default: ;
          endcase
          pix_d = pix_q + STEP_P;
          // Final step of the cell lands the sprite on the next centre.
          if (pix_q == CELL_P - STEP_P) begin
            done_d   = 1'b1;
            dir_d    = 4'b0000;
            moving_d = 1'b0;
            state_d  = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      req_q     <= 4'b0000;
      wait_q    <= '0;
      pix_q     <= '0;
      x_q       <= RST_X;
      y_q       <= RST_Y;
      dir_q     <= 4'b0000;
      moving_q  <= 1'b0;
      done_q    <= 1'b0;
      blocked_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      req_q     <= req_d;
      wait_q    <= wait_d;
      pix_q     <= pix_d;
      x_q       <= x_d;
      y_q       <= y_d;
      dir_q     <= dir_d;
      moving_q  <= moving_d;
      done_q    <= done_d;
      blocked_q <= blocked_d;
    end
  end

  assign pos_x     = x_q;
  assign pos_y     = y_q;
  assign dir       = dir_q;
  assign moving    = moving_q;
  assign move_done = done_q;
  assign blocked   = blocked_q;

endmodule

// File: tb/tb_player_move_controller.sv
// Bench for player_move_controller: directed scenarios plus randomized moves
// checked against a cell-level model of where the sprite should end up and when.
`timescale 1ns/1ps
module tb_player_move_controller;

  localparam int START_X = 455;
  localparam int START_Y = 146;
  localparam int CELL    = 16;
  localparam int STEP    = 2;
  localparam int DET_LAT = 2;
  localparam int X0      = 343;
  localparam int Y0      = 34;
  localparam int GMAX    = 20;

  logic        clk = 1'b0;
  logic        rst;
  logic        frame_tick;
  logic [3:0]  btn;
  logic [3:0]  valid_moves;
  logic [10:0] pos_x;
  logic [9:0]  pos_y;
  logic [3:0]  dir;
  logic        moving;
  logic        move_done;
  logic        blocked;

  int tests = 0;
  int fails = 0;
  int exp_x;
  int exp_y;

  always #5 clk = ~clk;

  player_move_controller #(
    .START_X(START_X), .START_Y(START_Y), .CELL(CELL), .STEP(STEP), .DET_LAT(DET_LAT)
  ) dut (
    .clk(clk), .rst(rst), .frame_tick(frame_tick), .btn(btn), .valid_moves(valid_moves),
    .pos_x(pos_x), .pos_y(pos_y), .dir(dir), .moving(moving),
    .move_done(move_done), .blocked(blocked)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Requested direction: highest-ranked pressed button in the order left, down, up, right.
  function automatic logic [3:0] pick(input logic [3:0] b);
    int order [4] = '{3, 2, 1, 0};
    foreach (order[i]) if (b[order[i]]) return 4'(1 << order[i]);
    return 4'b0000;
  endfunction

  task automatic chk_pos(input string tag);
    chk({tag, "_x"}, 32'(pos_x), 32'(exp_x));
    chk({tag, "_y"}, 32'(pos_y), 32'(exp_y));
  endtask

  // One request from IDLE; abort_after >= 0 stops watching after that many ticks.
  task automatic do_move(input logic [3:0] b, input logic [3:0] vm, input bit hold,
                         input int abort_after, input bit noise);
    logic [3:0] req;
    int dx, dy, ticks, cyc;
    bit legal, aborted;
    req     = pick(b);
    legal   = (req & vm) != 4'b0000;
    dx      = (req == 4'b0001) ? 1 : (req == 4'b1000) ? -1 : 0;
    dy      = (req == 4'b0100) ? 1 : (req == 4'b0010) ? -1 : 0;
    aborted = 1'b0;
    btn = b; valid_moves = vm; frame_tick = 1'b0;
    for (int k = 1; k <= DET_LAT + 1; k++) begin
      step();
      chk("wait_moving", 32'(moving), 0);
      chk("wait_pulses", 32'({move_done, blocked}), 0);
      chk_pos("wait_pos");
      btn        = noise ? 4'($urandom) : b;
      frame_tick = noise ? ($urandom_range(0, 1) == 1) : 1'b0;
    end
    step();
    if (!legal) begin
      chk("blocked_pulse", 32'(blocked), 1);
      chk("blocked_moving", 32'(moving), 0);
      chk("blocked_dir", 32'(dir), 0);
      chk("blocked_done", 32'(move_done), 0);
      chk_pos("blocked_pos");
    end else begin
      chk("enter_moving", 32'(moving), 1);
      chk("enter_dir", 32'(dir), 32'(req));
      chk("enter_pulses", 32'({move_done, blocked}), 0);
      chk_pos("enter_pos");
      ticks = 0;
      for (cyc = 0; cyc < 400; cyc++) begin
        bit t;
        t = ($urandom_range(0, 2) == 0);
        frame_tick = t;
        btn = noise ? 4'($urandom) : b;
        step();
        if (t) begin
          ticks++;
          exp_x += dx * STEP;
          exp_y += dy * STEP;
        end
        chk_pos("move_pos");
        if (ticks == CELL / STEP) begin
          chk("done_pulse", 32'(move_done), 1);
          chk("done_moving", 32'(moving), 0);
          chk("done_dir", 32'(dir), 0);
          chk("done_blocked", 32'(blocked), 0);
          break;
        end
        chk("move_done_early", 32'(move_done), 0);
        chk("move_moving", 32'(moving), 1);
        chk("move_dir", 32'(dir), 32'(req));
        if (abort_after >= 0 && ticks == abort_after) begin
          aborted = 1'b1;
          break;
        end
      end
      if (cyc == 400) chk("move_timeout", 32'(ticks), 32'(CELL / STEP));
    end
    frame_tick = 1'b0;
    btn = hold ? b : 4'b0000;
    if (!hold && !aborted) begin
      frame_tick = noise ? ($urandom_range(0, 1) == 1) : 1'b0;
      step();
      chk("gap_pulses", 32'({move_done, blocked}), 0);
      chk("gap_moving", 32'(moving), 0);
      chk_pos("gap_pos");
      frame_tick = 1'b0;
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int col, row;
    logic [3:0] b, vm;
    rst = 1'b1; frame_tick = 1'b1; btn = 4'b1111; valid_moves = 4'b1111;
    exp_x = START_X; exp_y = START_Y;
    step();
    step();
    chk_pos("reset_pos");
    chk("reset_dir", 32'(dir), 0);
    chk("reset_moving", 32'(moving), 0);
    chk("reset_pulses", 32'({move_done, blocked}), 0);
    rst = 1'b0; frame_tick = 1'b0; btn = 4'b0000;
    step();
    chk("post_reset_moving", 32'(moving), 0);
    chk_pos("post_reset_pos");

    // Legal up move from the start cell.
    do_move(4'b0010, 4'b1110, 1'b0, -1, 1'b0);
    chk("up_final_x", 32'(pos_x), 455);
    chk("up_final_y", 32'(pos_y), 130);

    // Right is closed: expect a block and no motion.
    do_move(4'b0001, 4'b1110, 1'b0, -1, 1'b0);
    chk("block_x", 32'(pos_x), 455);

    // Left beats right; noise on btn during the move must not reverse it.
    do_move(4'b1001, 4'b1111, 1'b0, -1, 1'b1);
    chk("prio_left_x", 32'(pos_x), 439);

    // Held down for three consecutive cells.
    for (int i = 0; i < 3; i++) do_move(4'b0100, 4'b1111, i < 2, -1, 1'b0);
    chk("hold_down_y", 32'(pos_y), 178);

    // Reset three ticks into a right move, with tick and button asserted alongside.
    do_move(4'b0001, 4'b1111, 1'b0, 3, 1'b0);
    rst = 1'b1; frame_tick = 1'b1; btn = 4'b1000;
    step();
    exp_x = START_X; exp_y = START_Y;
    chk_pos("midrst_pos");
    chk("midrst_moving", 32'(moving), 0);
    chk("midrst_dir", 32'(dir), 0);
    chk("midrst_done", 32'(move_done), 0);
    rst = 1'b0; btn = 4'b0000;
    step();
    chk("midrst_after_done", 32'(move_done), 0);
    chk("midrst_after_moving", 32'(moving), 0);
    chk_pos("midrst_after_pos");
    frame_tick = 1'b0;

    // Randomized moves kept inside a bounded grid region.
    for (int n = 0; n < 40; n++) begin
      col = (exp_x - X0) / CELL;
      row = (exp_y - Y0) / CELL;
      b   = 4'($urandom_range(1, 15));
      vm  = 4'($urandom_range(0, 15));
      if (col == 0)    vm[3] = 1'b0;
      if (col == GMAX) vm[0] = 1'b0;
      if (row == 0)    vm[1] = 1'b0;
      if (row == GMAX) vm[2] = 1'b0;
      do_move(b, vm, $urandom_range(0, 1) == 1, -1, 1'b1);
    end
    btn = 4'b0000;
    step();
    chk("final_pulses", 32'({move_done, blocked}), 0);
    chk_pos("final_pos");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
